// File: rtl/prefix_adder_pipe.sv
// Pipelined Sklansky prefix adder/subtractor with a valid/ready stream interface.
// Operands are registered, the prefix tree is optionally cut by INT_STAGES registers, the result is registered.
module prefix_adder_pipe #(
    parameter int WIDTH      = 16,
    parameter int INT_STAGES = 1,
    parameter int SIGNED     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int L = $clog2(WIDTH);
    localparam int N = 1 << L;

    // True when a register cut follows prefix level lvl.
    function automatic bit is_cut(input int lvl);
        bit r;
        r = 1'b0;
        for (int k = 1; k <= INT_STAGES; k++) begin
            if ((k * L) / (INT_STAGES + 1) == lvl) r = 1'b1;
        end
        return r;
    endfunction

    // Handshake: a beat transfers on an edge where valid && ready. The whole
    // pipe advances together; it holds only when the output is full and not
    // taken, so in_ready is simply the inverse of that stall (gated by reset).
    logic stall;
    logic advance;
    assign stall    = out_valid & ~out_ready;
    assign advance  = ~stall;
    assign in_ready = rst_n & ~stall;

    logic [WIDTH-1:0] a_q, b_eff_q, b_eff_d;
    logic             c0_q, c0_d, sub_q, in_v_q;

    assign b_eff_d = sub ? ~b : b;
    assign c0_d    = sub | cin;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_v_q  <= 1'b0;
            a_q     <= '0;
            b_eff_q <= '0;
            c0_q    <= 1'b0;
            sub_q   <= 1'b0;
        end else if (advance) begin
            in_v_q  <= in_valid;
            a_q     <= a;
            b_eff_q <= b_eff_d;
            c0_q    <= c0_d;
            sub_q   <= sub;
        end
    end

    // Per-level tree state plus the sideband that must travel with it.
    logic [N-1:0]     g_lv   [L+1];
    logic [N-1:0]     p_lv   [L+1];
    logic [WIDTH-1:0] sb_p   [L+1];
    logic             sb_c0  [L+1];
    logic             sb_sub [L+1];
    logic             sb_v   [L+1];

    logic [WIDTH-1:0] gen0, prop0;
    logic [N-1:0]     g_base, p_base;

    assign gen0  = a_q & b_eff_q;
    assign prop0 = a_q ^ b_eff_q;

    // Carry-in is folded into bit 0 so every prefix G[i:0] already spans bit -1.
    // Pad bits above WIDTH stay 0 and only ever feed higher (discarded) bits.
    always_comb begin
        g_base            = '0;
        p_base            = '0;
        g_base[WIDTH-1:0] = gen0;
        p_base[WIDTH-1:0] = prop0;
        g_base[0]         = gen0[0] | (prop0[0] & c0_q);
    end

    assign g_lv[0]   = g_base;
    assign p_lv[0]   = p_base;
    assign sb_p[0]   = prop0;
    assign sb_c0[0]  = c0_q;
    assign sb_sub[0] = sub_q;
    assign sb_v[0]   = in_v_q;

    for (genvar l = 1; l <= L; l++) begin : g_level
        logic [N-1:0] lvl_g, lvl_p;

        // Upper half of each 2^l group combines with the top bit of its lower half.
        always_comb begin
            lvl_g = g_lv[l-1];
            lvl_p = p_lv[l-1];
            for (int i = 0; i < N; i++) begin
                if (((i >> (l - 1)) & 1) == 1) begin
                    lvl_g[i] = g_lv[l-1][i] | (p_lv[l-1][i] & g_lv[l-1][((i >> (l - 1)) << (l - 1)) - 1]);
                    lvl_p[i] = p_lv[l-1][i] & p_lv[l-1][((i >> (l - 1)) << (l - 1)) - 1];
                end
            end
        end

        if (is_cut(l)) begin : g_cut
            logic [N-1:0]     cg_q, cp_q;
            logic [WIDTH-1:0] cs_q;
            logic             cc_q, csub_q, cv_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cg_q   <= '0;
                    cp_q   <= '0;
                    cs_q   <= '0;
                    cc_q   <= 1'b0;
                    csub_q <= 1'b0;
                    cv_q   <= 1'b0;
                end else if (advance) begin
                    cg_q   <= lvl_g;
                    cp_q   <= lvl_p;
                    cs_q   <= sb_p[l-1];
                    cc_q   <= sb_c0[l-1];
                    csub_q <= sb_sub[l-1];
                    cv_q   <= sb_v[l-1];
                end
            end

            assign g_lv[l]   = cg_q;
            assign p_lv[l]   = cp_q;
            assign sb_p[l]   = cs_q;
            assign sb_c0[l]  = cc_q;
            assign sb_sub[l] = csub_q;
            assign sb_v[l]   = cv_q;
        end else begin : g_pass
            assign g_lv[l]   = lvl_g;
            assign p_lv[l]   = lvl_p;
            assign sb_p[l]   = sb_p[l-1];
            assign sb_c0[l]  = sb_c0[l-1];
            assign sb_sub[l] = sb_sub[l-1];
            assign sb_v[l]   = sb_v[l-1];
        end
    end

    logic [WIDTH-1:0] carry_d, sum_d;
    logic             cout_d, ovf_d;

    assign carry_d = {g_lv[L][WIDTH-2:0], sb_c0[L]};
    assign sum_d   = sb_p[L] ^ carry_d;
    assign cout_d  = g_lv[L][WIDTH-1];
    assign ovf_d   = (SIGNED != 0) ? (carry_d[WIDTH-1] ^ cout_d) : (cout_d ^ sb_sub[L]);

    logic unused_tree;
    assign unused_tree = ^{p_lv[L], g_lv[L]};

    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q, out_v_q;

    // Result fields are zeroed whenever the slot is empty so idle outputs are clean.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_v_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (advance) begin
            out_v_q <= sb_v[L];
            sum_q   <= sb_v[L] ? sum_d  : '0;
            cout_q  <= sb_v[L] ? cout_d : 1'b0;
            ovf_q   <= sb_v[L] ? ovf_d  : 1'b0;
        end
    end

    assign out_valid = out_v_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
